// File: rtl/alu_pkg.sv
// Shared op codes and controller state encoding for the ALU issue front end.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the ALU op table, used to cross-check the real ALU.
module alu_ref_model
    import alu_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    output logic [31:0] result_o,
    output logic        zero_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_AND: result_o = src1_i & src2_i;
            ALU_OR:  result_o = src1_i | src2_i;
            ALU_ADD: result_o = src1_i + src2_i;
            ALU_SUB: result_o = src1_i - src2_i;
            ALU_MUL: result_o = src1_i * src2_i;
            ALU_SLT: result_o = {31'd0, $signed(src1_i) < $signed(src2_i)};
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Clocked valid/ready front end for the combinational 32-bit ALU.
// Define ALU_ISSUE_CHECK_EN to build the golden-model checker driving Err_Count.
//
// state      | meaning
// ST_IDLE    | ready for a request, ALU inputs hold last issued values
// ST_ISSUE   | ALU inputs held while the settle counter runs down
// ST_CAPTURE | ALU result and zero flag registered into the response
// ST_RESP    | response offered until the consumer takes it
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic [31:0] Req_Src1,
    input  logic [31:0] Req_Src2,
    input  logic [2:0]  Req_Op,
    output logic [31:0] ALU_Src1,
    output logic [31:0] ALU_Src2,
    output logic [2:0]  ALU_Control,
    input  logic [31:0] ALU_Result,
    input  logic        Zero_Flag,
    output logic        Rsp_Valid,
    input  logic        Rsp_Ready,
    output logic [31:0] Rsp_Result,
    output logic        Rsp_Zero,
    output logic [2:0]  Rsp_Op,
    output logic [7:0]  Err_Count
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] src1_q, src2_q, res_q;
    logic [2:0]  ctrl_q, op_q;
    logic        zero_q;
    logic        accept, capture;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (Req_Valid) begin
                    state_d = ST_ISSUE;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            ST_ISSUE: begin
                if (cnt_q == 4'd0) state_d = ST_CAPTURE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP: begin
                if (Rsp_Ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        Req_Ready = (state_q == ST_IDLE);
        Rsp_Valid = (state_q == ST_RESP);
        accept    = Req_Ready && Req_Valid;
        capture   = (state_q == ST_CAPTURE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            src1_q <= '0;
            src2_q <= '0;
            ctrl_q <= '0;
            op_q   <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            if (accept) begin
                src1_q <= Req_Src1;
                src2_q <= Req_Src2;
                ctrl_q <= Req_Op;
                op_q   <= Req_Op;
            end
            if (capture) begin
                res_q  <= ALU_Result;
                zero_q <= Zero_Flag;
            end
        end
    end

    assign ALU_Src1    = src1_q;
    assign ALU_Src2    = src2_q;
    assign ALU_Control = ctrl_q;
    assign Rsp_Result  = res_q;
    assign Rsp_Zero    = zero_q;
    assign Rsp_Op      = op_q;

`ifdef ALU_ISSUE_CHECK_EN
    logic [31:0] gold_res;
    logic        gold_zero;
    logic [7:0]  err_q;

    alu_ref_model u_ref (
        .op_i    (ctrl_q),
        .src1_i  (src1_q),
        .src2_i  (src2_q),
        .result_o(gold_res),
        .zero_o  (gold_zero)
    );

    // Saturates so a persistently broken ALU never wraps back to a clean count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q <= '0;
        end else if (capture && ((ALU_Result != gold_res) || (Zero_Flag != gold_zero))
                     && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign Err_Count = err_q;
`else
    assign Err_Count = '0;
`endif

endmodule
